// File: rtl/demux_pkg.sv
// Shared definitions for the buffered 1-to-2 nibble demultiplexer.
// Holds default sizes, route-select encodings and the channel FIFO state type.
package demux_pkg;

   localparam int WIDTH_DEF = 4;
   localparam int DEPTH_DEF = 2;
   localparam int CNT_W_DEF = 8;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   typedef enum logic {
      EMPTY    = 1'b0,
      NONEMPTY = 1'b1
   } fifo_state_t;

endpackage

// File: rtl/demux_chan_fifo.sv
// One output channel: small FIFO with valid/ready pop, registered full flag,
// zero-gated head data and a wrapping delivered-nibble counter.
module demux_chan_fifo
   import demux_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             ready,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic             full,
   output logic [CNT_W-1:0] count,
   output fifo_state_t      state
);

   localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
   localparam int OCC_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [OCC_W-1:0] occ_q;
   logic [OCC_W-1:0] occ_d;
   logic [CNT_W-1:0] cnt_q;
   logic             full_q;
   logic             push_ok;
   logic             pop;
   fifo_state_t      state_q;
   fifo_state_t      state_d;

   // A push into a full channel is dropped here as well as being gated upstream.
   assign push_ok = push && !full_q;
   assign pop     = (state_q == NONEMPTY) && ready;

   always_comb begin
      occ_d   = occ_q;
      state_d = state_q;
      case ({push_ok, pop})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase
      case (state_q)
         EMPTY:    if (push_ok) state_d = NONEMPTY;
         NONEMPTY: if (occ_d == '0) state_d = EMPTY;
         default:  state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= EMPTY;
         occ_q   <= '0;
         full_q  <= 1'b0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         occ_q   <= occ_d;
         full_q  <= (occ_d == OCC_W'(DEPTH));
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            cnt_q  <= cnt_q + CNT_W'(1);
         end
      end
   end

   // Storage needs no reset: the head is gated to zero while empty.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   assign valid = (state_q == NONEMPTY);
   assign data  = valid ? mem[rd_ptr] : '0;
   assign full  = full_q;
   assign count = cnt_q;
   assign state = state_q;

endmodule

// File: rtl/demux2_4_buf.sv
// Buffered 1-to-2 nibble demultiplexer: routes each accepted input to channel A or B
// by s; each channel buffers independently so one stalled consumer never blocks the other.
module demux2_4_buf
   import demux_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] In,
   input  logic             in_valid,
   input  logic             s,
   output logic             in_ready,
   output logic [WIDTH-1:0] A,
   output logic             a_valid,
   input  logic             a_ready,
   output logic [WIDTH-1:0] B,
   output logic             b_valid,
   input  logic             b_ready,
   output logic [CNT_W-1:0] a_count,
   output logic [CNT_W-1:0] b_count,
   output fifo_state_t      a_state,
   output fifo_state_t      b_state
);

   // Handshake: a transfer happens on a rising edge where valid && ready; valid
   // never waits on ready, and in_ready looks only at s and registered full flags.
   logic a_full;
   logic b_full;
   logic push_a;
   logic push_b;

   assign in_ready = (s == SEL_A) ? !a_full : !b_full;
   assign push_a   = in_valid && in_ready && (s == SEL_A);
   assign push_b   = in_valid && in_ready && (s == SEL_B);

   demux_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_chan_a (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push_a),
      .push_data (In),
      .ready     (a_ready),
      .data      (A),
      .valid     (a_valid),
      .full      (a_full),
      .count     (a_count),
      .state     (a_state)
   );

   demux_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_chan_b (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push_b),
      .push_data (In),
      .ready     (b_ready),
      .data      (B),
      .valid     (b_valid),
      .full      (b_full),
      .count     (b_count),
      .state     (b_state)
   );

endmodule

// File: tb/tb_demux2_4_buf.sv
// Bench for demux2_4_buf: queue-based channel model compared every cycle, plus
// directed scenarios with literal expectations and a randomized traffic phase.
module tb_demux2_4_buf;
   import demux_pkg::*;

   localparam int W     = 4;
   localparam int DEPTH = 2;
   localparam int CW    = 8;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [W-1:0]  in_d;
   logic          in_valid;
   logic          s;
   logic          in_ready;
   logic [W-1:0]  a_d;
   logic          a_valid;
   logic          a_ready;
   logic [W-1:0]  b_d;
   logic          b_valid;
   logic          b_ready;
   logic [CW-1:0] a_count;
   logic [CW-1:0] b_count;
   fifo_state_t   a_state;
   fifo_state_t   b_state;

   int n_tests = 0;
   int n_fail  = 0;
   bit started = 1'b0;

   // model: per-channel contents, delivered counts and a log of delivered nibbles
   logic [W-1:0] exp_a_q[$];
   logic [W-1:0] exp_b_q[$];
   logic [W-1:0] log_a_q[$];
   logic [W-1:0] log_b_q[$];
   int           cnt_a = 0;
   int           cnt_b = 0;

   demux2_4_buf #(.WIDTH(W), .DEPTH(DEPTH), .CNT_W(CW)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .In       (in_d),
      .in_valid (in_valid),
      .s        (s),
      .in_ready (in_ready),
      .A        (a_d),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .B        (b_d),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .a_count  (a_count),
      .b_count  (b_count),
      .a_state  (a_state),
      .b_state  (b_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         exp_a_q.delete();
         exp_b_q.delete();
         cnt_a = 0;
         cnt_b = 0;
      end else begin
         bit pop_a, pop_b, push_a, push_b;
         pop_a  = (exp_a_q.size() > 0) && a_ready;
         pop_b  = (exp_b_q.size() > 0) && b_ready;
         push_a = in_valid && (s == 1'b0) && (exp_a_q.size() < DEPTH);
         push_b = in_valid && (s == 1'b1) && (exp_b_q.size() < DEPTH);
         if (pop_a) begin
            log_a_q.push_back(exp_a_q.pop_front());
            cnt_a = (cnt_a + 1) % 256;
         end
         if (pop_b) begin
            log_b_q.push_back(exp_b_q.pop_front());
            cnt_b = (cnt_b + 1) % 256;
         end
         if (push_a) exp_a_q.push_back(in_d);
         if (push_b) exp_b_q.push_back(in_d);
      end
   end

   always @(negedge clk) begin
      #3;
      if (started) begin
         check("in_ready", in_ready,
               ((s ? exp_b_q.size() : exp_a_q.size()) < DEPTH) ? 1 : 0);
         check("a_valid", a_valid, (exp_a_q.size() > 0) ? 1 : 0);
         check("b_valid", b_valid, (exp_b_q.size() > 0) ? 1 : 0);
         check("A_head", a_d, (exp_a_q.size() > 0) ? exp_a_q[0] : 4'h0);
         check("B_head", b_d, (exp_b_q.size() > 0) ? exp_b_q[0] : 4'h0);
         check("a_count", a_count, cnt_a);
         check("b_count", b_count, cnt_b);
         check("a_state", a_state, (exp_a_q.size() > 0) ? NONEMPTY : EMPTY);
         check("b_state", b_state, (exp_b_q.size() > 0) ? NONEMPTY : EMPTY);
      end
   end

   task automatic send(input logic sel, input logic [W-1:0] d);
      in_valid = 1'b1;
      s        = sel;
      in_d     = d;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      reset_n  = 1'b0;
      in_valid = 1'b1;
      s        = 1'b0;
      in_d     = 4'hF;
      a_ready  = 1'b0;
      b_ready  = 1'b0;

      // reset held with in_valid high
      @(negedge clk);
      started = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_a_valid", a_valid, 0);
      check("rst_b_valid", b_valid, 0);
      check("rst_A", a_d, 0);
      check("rst_B", b_d, 0);
      check("rst_a_count", a_count, 0);
      check("rst_b_count", b_count, 0);
      check("rst_in_ready_a", in_ready, 1);
      s = 1'b1;
      #1;
      check("rst_in_ready_b", in_ready, 1);
      @(negedge clk);
      reset_n  = 1'b1;
      in_valid = 1'b0;

      // routing and order
      a_ready = 1'b1;
      b_ready = 1'b1;
      send(1'b0, 4'h3);
      send(1'b1, 4'hC);
      send(1'b0, 4'h5);
      idle(3);
      check("route_log_a_size", log_a_q.size(), 2);
      check("route_a0", log_a_q[0], 4'h3);
      check("route_a1", log_a_q[1], 4'h5);
      check("route_log_b_size", log_b_q.size(), 1);
      check("route_b0", log_b_q[0], 4'hC);
      check("route_a_count", a_count, 2);
      check("route_b_count", b_count, 1);
      log_a_q.delete();
      log_b_q.delete();

      // A full and stalled; B keeps flowing
      a_ready = 1'b0;
      send(1'b0, 4'h1);
      send(1'b0, 4'h2);
      in_valid = 1'b1;
      s        = 1'b0;
      in_d     = 4'h8;
      #1;
      check("full_in_ready_a", in_ready, 0);
      s    = 1'b1;
      in_d = 4'h9;
      #1;
      check("full_in_ready_b", in_ready, 1);
      @(negedge clk);
      idle(2);
      check("stall_log_b_size", log_b_q.size(), 1);
      check("stall_b0", log_b_q[0], 4'h9);
      check("stall_log_a_size", log_a_q.size(), 0);
      check("stall_a_valid", a_valid, 1);
      check("stall_A", a_d, 4'h1);

      // full with pop: pop 1 with no push, then 7 accepted next cycle
      a_ready  = 1'b1;
      s        = 1'b0;
      in_d     = 4'h7;
      in_valid = 1'b1;
      #1;
      check("fullpop_in_ready0", in_ready, 0);
      @(negedge clk);
      #1;
      check("fullpop_in_ready1", in_ready, 1);
      check("fullpop_A", a_d, 4'h2);
      @(negedge clk);
      idle(3);
      check("fullpop_log_size", log_a_q.size(), 3);
      check("fullpop_a0", log_a_q[0], 4'h1);
      check("fullpop_a1", log_a_q[1], 4'h2);
      check("fullpop_a2", log_a_q[2], 4'h7);
      check("fullpop_a_count", a_count, 5);
      log_a_q.delete();
      log_b_q.delete();

      // counter wrap: 254 more on B reaches 256 total, then 2 more
      b_ready = 1'b1;
      for (int i = 0; i < 254; i++) send(1'b1, 4'($urandom_range(0, 15)));
      idle(3);
      check("wrap_log_b_size", log_b_q.size(), 254);
      check("wrap_b_count", b_count, 0);
      check("wrap_a_count", a_count, 5);
      send(1'b1, 4'hA);
      send(1'b1, 4'hB);
      idle(3);
      check("wrap_b_count2", b_count, 2);

      // reset with A holding two entries
      a_ready = 1'b0;
      send(1'b0, 4'h4);
      send(1'b0, 4'h6);
      in_valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      check("mrst_a_valid", a_valid, 0);
      check("mrst_A", a_d, 0);
      check("mrst_in_ready", in_ready, 1);
      check("mrst_a_count", a_count, 0);
      check("mrst_b_count", b_count, 0);
      @(negedge clk);
      reset_n = 1'b1;
      log_a_q.delete();
      log_b_q.delete();
      a_ready = 1'b1;
      send(1'b0, 4'hE);
      idle(3);
      check("mrst_log_size", log_a_q.size(), 1);
      check("mrst_first", log_a_q[0], 4'hE);
      check("mrst_a_count2", a_count, 1);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         s        = 1'($urandom_range(0, 1));
         in_d     = 4'($urandom_range(0, 15));
         a_ready  = ($urandom_range(0, 2) != 0);
         b_ready  = ($urandom_range(0, 3) == 0);
         @(negedge clk);
      end
      a_ready = 1'b1;
      b_ready = 1'b1;
      idle(5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
